// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, starvation limit default and writeback source encoding
package wb_port_arbiter_pkg;
  localparam int REG_DATA_WIDTH = 32;
  localparam int RS_WIDTH = 5;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CW = 4;
  typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_A, WB_SRC_B} wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-rd vector for long-latency writes, issue check, ID busy queries, WAW flag
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
#(
  parameter int REG_AW = RS_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_gnt,
  input  logic [REG_AW-1:0] a_rd,
  input  logic              b_gnt,
  input  logic [REG_AW-1:0] b_rd,
  input  logic              b_issue,
  input  logic [REG_AW-1:0] b_issue_rd,
  input  logic [REG_AW-1:0] rs1_q,
  input  logic [REG_AW-1:0] rs2_q,
  output logic              issue_ok,
  output logic              busy1,
  output logic              busy2,
  output logic              waw_err
);
  localparam int NREG = 1 << REG_AW;
  logic [NREG-1:0] pend, pend_n;
  always_comb begin
    issue_ok = (b_issue_rd == '0) || !pend[b_issue_rd] || (b_gnt && b_rd == b_issue_rd);
    pend_n = pend;
    if (b_gnt) pend_n[b_rd] = 1'b0;
    // issue is applied after the clear so a same-rd reissue stays pending
    if (b_issue && issue_ok && b_issue_rd != '0) pend_n[b_issue_rd] = 1'b1;
  end
  assign busy1 = pend[rs1_q];
  assign busy2 = pend[rs2_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      waw_err <= 1'b0;
    end else begin
      pend <= pend_n;
      waw_err <= waw_err | (a_gnt & (a_rd != '0) & pend[a_rd]);
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WB (A) and the long-latency unit (B).
// Optional WB_PORT_ARBITER_BYPASS_EN adds forwarding of the in-flight write to ID.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int REG_AW = RS_WIDTH,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_issue,
  input  logic [REG_AW-1:0] b_issue_rd,
  output logic              issue_ok,
  input  logic [REG_AW-1:0] rs1_q,
  input  logic [REG_AW-1:0] rs2_q,
  output logic              busy1,
  output logic              busy2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef WB_PORT_ARBITER_BYPASS_EN
  output logic              byp1,
  output logic              byp2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2,
`endif
  output logic              waw_err
);
  logic [STARVE_CW-1:0] starve_cnt;
  logic starved;
  wb_src_e src;
  logic [REG_AW-1:0] g_rd;
  logic [DATA_W-1:0] g_data;
  assign starved = starve_cnt == STARVE_CW'(STARVE_LIMIT);
  always_comb begin
    b_ready = b_valid & (!a_valid | starved);
    a_ready = a_valid & !b_ready;
    src = b_ready ? WB_SRC_B : a_ready ? WB_SRC_A : WB_SRC_NONE;
    g_rd = (src == WB_SRC_B) ? b_rd : a_rd;
    g_data = (src == WB_SRC_B) ? b_data : a_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wdata <= '0;
    end else begin
      starve_cnt <= (!b_valid || b_ready) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
      // x0 writes are accepted but never reach the register file
      rf_we <= (src != WB_SRC_NONE) && (g_rd != '0);
      if (src != WB_SRC_NONE) begin
        rf_rd <= g_rd;
        rf_wdata <= g_data;
      end
    end
  end
  wb_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk(clk),
    .rst(rst),
    .a_gnt(a_ready),
    .a_rd(a_rd),
    .b_gnt(b_ready),
    .b_rd(b_rd),
    .b_issue(b_issue),
    .b_issue_rd(b_issue_rd),
    .rs1_q(rs1_q),
    .rs2_q(rs2_q),
    .issue_ok(issue_ok),
    .busy1(busy1),
    .busy2(busy2),
    .waw_err(waw_err)
  );
`ifdef WB_PORT_ARBITER_BYPASS_EN
  assign byp1 = rf_we && rf_rd == rs1_q && rs1_q != '0;
  assign byp2 = rf_we && rf_rd == rs2_q && rs2_q != '0;
  assign byp_data1 = rf_wdata;
  assign byp_data2 = rf_wdata;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table, starvation/reset sequences and random run against a reference model
module tb_wb_port_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst, a_valid, a_ready, b_valid, b_ready, b_issue, issue_ok, busy1, busy2, rf_we, waw_err;
  logic [4:0] a_rd, b_rd, b_issue_rd, rs1_q, rs2_q, rf_rd;
  logic [31:0] a_data, b_data, rf_wdata;
`ifdef WB_PORT_ARBITER_BYPASS_EN
  logic byp1, byp2;
  logic [31:0] byp_data1, byp_data2;
`endif
  wb_port_arbiter #(.DATA_W(32), .REG_AW(5), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .b_issue(b_issue), .b_issue_rd(b_issue_rd), .issue_ok(issue_ok),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .busy1(busy1), .busy2(busy2),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
`ifdef WB_PORT_ARBITER_BYPASS_EN
    .byp1(byp1), .byp2(byp2), .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
    .waw_err(waw_err)
  );
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: set of pending registers, count of cycles B has waited, last write seen by the RF
  bit m_pend[32];
  int m_wait;
  logic m_we, m_waw;
  logic [4:0] m_rd;
  logic [31:0] m_wd;
  logic e_ar, e_br, e_ok;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wait = 0; m_we = 1'b0; m_waw = 1'b0; m_rd = '0; m_wd = '0;
  endtask

  task automatic step();
    #1;
    e_br = b_valid && (!a_valid || m_wait >= LIM);
    e_ar = a_valid && !e_br;
    e_ok = (b_issue_rd == 0) || !m_pend[b_issue_rd] || (e_br && b_rd == b_issue_rd);
    check("a_ready", a_ready, e_ar);
    check("b_ready", b_ready, e_br);
    check("issue_ok", issue_ok, e_ok);
    check("busy1", busy1, m_pend[rs1_q]);
    check("busy2", busy2, m_pend[rs2_q]);
    check("rf_we", rf_we, m_we);
    check("rf_rd", rf_rd, m_rd);
    check("rf_wdata", rf_wdata, m_wd);
    check("waw_err", waw_err, m_waw);
`ifdef WB_PORT_ARBITER_BYPASS_EN
    check("byp1", byp1, m_we && m_rd == rs1_q && rs1_q != 0);
    check("byp2", byp2, m_we && m_rd == rs2_q && rs2_q != 0);
    if (byp1) check("byp_data1", byp_data1, m_wd);
    if (byp2) check("byp_data2", byp_data2, m_wd);
`endif
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (e_ar) begin
        if (a_rd != 0 && m_pend[a_rd]) m_waw = 1'b1;
        m_we = a_rd != 0; m_rd = a_rd; m_wd = a_data;
      end else if (e_br) begin
        m_we = b_rd != 0; m_rd = b_rd; m_wd = b_data;
      end else m_we = 1'b0;
      if (e_br) m_pend[b_rd] = 1'b0;
      if (b_issue && e_ok && b_issue_rd != 0) m_pend[b_issue_rd] = 1'b1;
      m_wait = (!b_valid || e_br) ? 0 : (m_wait < LIM ? m_wait + 1 : LIM);
    end
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
    b_issue = 0; b_issue_rd = 0; rs1_q = 0; rs2_q = 0; rst = 0;
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic bv; logic [4:0] brd; logic [31:0] bd;
    logic bi; logic [4:0] bird; logic [4:0] r1; logic [4:0] r2;
    logic ar; logic br; logic ok; logic b1; logic b2;
    logic we; logic [4:0] rd; logic [31:0] wd; logic waw;
  } vec_t;
  vec_t tab[14];

  initial begin
    tab[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0};
    tab[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b0};
    tab[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b0};
    tab[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0};
    tab[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77, 1'b0};
    tab[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77, 1'b0};
    tab[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99, 1'b0};
    tab[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h99, 1'b0};
    tab[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h5, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h5, 1'b0};
    tab[9]  = '{1'b1, 5'd0, 32'hAAAA, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hAAAA, 1'b0};
    tab[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hAAAA, 1'b0};
    tab[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hAAAA, 1'b0};
    tab[12] = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33, 1'b1};
    tab[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h33, 1'b1};

    idle();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    step();
    rst = 0;

    for (int i = 0; i < 14; i++) begin
      a_valid = tab[i].av; a_rd = tab[i].ard; a_data = tab[i].ad;
      b_valid = tab[i].bv; b_rd = tab[i].brd; b_data = tab[i].bd;
      b_issue = tab[i].bi; b_issue_rd = tab[i].bird; rs1_q = tab[i].r1; rs2_q = tab[i].r2;
      #1;
      check($sformatf("tab%0d_a_ready", i), a_ready, tab[i].ar);
      check($sformatf("tab%0d_b_ready", i), b_ready, tab[i].br);
      check($sformatf("tab%0d_issue_ok", i), issue_ok, tab[i].ok);
      check($sformatf("tab%0d_busy1", i), busy1, tab[i].b1);
      check($sformatf("tab%0d_busy2", i), busy2, tab[i].b2);
      step();
      check($sformatf("tab%0d_rf_we", i), rf_we, tab[i].we);
      check($sformatf("tab%0d_rf_rd", i), rf_rd, tab[i].rd);
      check($sformatf("tab%0d_rf_wdata", i), rf_wdata, tab[i].wd);
      check($sformatf("tab%0d_waw_err", i), waw_err, tab[i].waw);
    end

    idle();
    a_valid = 1; a_rd = 5'd1; a_data = 32'h11; b_valid = 1; b_rd = 5'd12; b_data = 32'hBB;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("starve%0d_a_ready", k), a_ready, k != 4);
      check($sformatf("starve%0d_b_ready", k), b_ready, k == 4);
      step();
    end

    idle();
    rs1_q = 5'd3;
    #1;
    check("pre_rst_busy1", busy1, 1'b1);
    check("pre_rst_waw", waw_err, 1'b1);
    a_valid = 1; a_rd = 5'd6; a_data = 32'hDEAD; rst = 1;
    step();
    idle();
    rs1_q = 5'd3;
    #1;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_rd", rf_rd, 5'd0);
    check("rst_rf_wdata", rf_wdata, 32'h0);
    check("rst_waw", waw_err, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    step();

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      a_valid = $urandom_range(0, 1) == 1;
      a_rd = 5'($urandom_range(0, 7));
      a_data = $urandom;
      b_valid = $urandom_range(0, 2) != 0;
      b_rd = 5'($urandom_range(0, 7));
      b_data = $urandom;
      b_issue = $urandom_range(0, 1) == 1;
      b_issue_rd = 5'($urandom_range(0, 7));
      rs1_q = 5'($urandom_range(0, 7));
      rs2_q = 5'($urandom_range(0, 7));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
